sm_debug_scan: RTL and testbench

SM_DEBUG_SCAN -- requirements
Module: sm_debug_scan

---
 rtl/sm_debug_scan.sv | 133 +++++++++++++
 tb/tb_sm_debug_scan.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_debug_scan.sv
// Debug scanner: steps or auto-scans a window of data memory and latches each word for a hex display.
// Optional leading-zero blanking of digit_en is enabled by defining SM_DEBUG_SCAN_BLANK_EN.
module sm_debug_scan #(
   parameter int DIGITS     = 6,
   parameter int ADDR_W     = 5,
   parameter int DEBOUNCE_W = 16,
   parameter int SCAN_W     = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_step,
   input  logic                  auto_en,
   input  logic [ADDR_W-1:0]     base_addr,
   output logic                  rd_req,
   output logic [ADDR_W-1:0]     rd_addr,
   input  logic [31:0]           rd_data,
   output logic [4*DIGITS-1:0]   disp_data,
   output logic [DIGITS-1:0]     digit_en,
   output logic [ADDR_W-1:0]     cur_addr,
   output logic                  busy
);

   localparam logic [1:0] S_INIT  = 2'd0;
   localparam logic [1:0] S_IDLE  = 2'd1;
   localparam logic [1:0] S_REQ   = 2'd2;
   localparam logic [1:0] S_LATCH = 2'd3;

   logic [1:0]            state, state_nxt;
   logic                  key_s1, key_s2;
   logic                  key_lvl;
   logic [DEBOUNCE_W-1:0] db_cnt;
   logic [SCAN_W-1:0]     scan_tmr;
   logic [ADDR_W-1:0]     offset, offset_nxt;
   logic                  pending;
   logic                  differ, db_full, step, tick, advance, refresh;

   // NOTE: every clocked process uses non-blocking assignments so all flops sample the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
      end else begin
         key_s1 <= key_step;
         key_s2 <= key_s1;
      end
   end

   // The level flips only after 2^DEBOUNCE_W consecutive disagreeing cycles.
   assign differ  = (key_s2 != key_lvl);
   assign db_full = &db_cnt;
   assign step    = differ && db_full && key_lvl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_lvl <= 1'b1;
         db_cnt  <= '0;
      end else if (!differ) begin
         db_cnt  <= '0;
      end else if (db_full) begin
         key_lvl <= key_s2;
         db_cnt  <= '0;
      end else begin
         db_cnt  <= db_cnt + 1'b1;
      end
   end

   assign tick = &scan_tmr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) scan_tmr <= '0;
      else     scan_tmr <= scan_tmr + 1'b1;
   end

   // A coincident step and auto tick collapse into a single advance.
   assign advance    = step || (tick && auto_en);
   assign refresh    = tick && !auto_en;
   assign offset_nxt = advance ? offset + 1'b1 : offset;

   // NOTE: the next-state default assignment keeps this combinational block latch-free.
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:  state_nxt = S_REQ;
         S_IDLE:  if (advance || refresh || pending) state_nxt = S_REQ;
         S_REQ:   state_nxt = S_LATCH;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_INIT;
         offset  <= '0;
         pending <= 1'b0;
         rd_addr <= '0;
      end else begin
         state  <= state_nxt;
         offset <= offset_nxt;
         // Read address is frozen on entry to REQ so later base/offset changes wait for the next read.
         if (state_nxt == S_REQ && state != S_REQ)
            rd_addr <= base_addr + offset_nxt;
         if (state == S_IDLE && state_nxt == S_REQ)
            pending <= 1'b0;
         else if (advance && (state == S_REQ || state == S_LATCH))
            pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_data <= '0;
         cur_addr  <= '0;
      end else if (state == S_LATCH) begin
         disp_data <= rd_data[4*DIGITS-1:0];
         cur_addr  <= rd_addr;
      end
   end

   assign rd_req = (state == S_REQ);
   assign busy   = (state == S_REQ) || (state == S_LATCH);

`ifdef SM_DEBUG_SCAN_BLANK_EN
   // Digit i is lit when it or any more significant nibble is nonzero; digit 0 is always lit.
   always_comb begin
      digit_en = '0;
      for (int i = 0; i < DIGITS; i++)
         digit_en[i] = (i == 0) || (|(disp_data >> (4 * i)));
   end
`else
   assign digit_en = '1;
`endif

endmodule

// File: tb/tb_sm_debug_scan.sv
// Self-checking bench for sm_debug_scan: directed scenarios plus a randomized auto-scan phase
// checked against a cycle-count/offset reference model.
module tb_sm_debug_scan;

   localparam int PERIOD = 16;

   typedef struct {
      logic [4:0] addr;
      int         pc;
   } rd_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_step;
   logic        auto_en;
   logic [4:0]  base_addr;
   logic        rd_req;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [23:0] disp_data;
   logic [5:0]  digit_en;
   logic [4:0]  cur_addr;
   logic        busy;

   logic [31:0] mem [32];
   rd_t         rlog [$];
   int          pcnt;
   int          auto_ticks;
   int          total = 0;
   int          bad   = 0;
   int          steps_m, merged_m;

   always #5 clk = ~clk;

   sm_debug_scan #(.DIGITS(6), .ADDR_W(5), .DEBOUNCE_W(2), .SCAN_W(4)) dut (
      .clk(clk), .rst(rst), .key_step(key_step), .auto_en(auto_en),
      .base_addr(base_addr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
      .disp_data(disp_data), .digit_en(digit_en), .cur_addr(cur_addr), .busy(busy)
   );

   // Memory answers one cycle after the strobe.
   always @(posedge clk) if (rd_req) rd_data <= mem[rd_addr];

   // Reference timebase: cycles since reset release; an auto tick lands every PERIOD cycles.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt       <= 0;
         auto_ticks <= 0;
      end else begin
         pcnt <= pcnt + 1;
         if (auto_en && (pcnt % PERIOD == PERIOD - 1)) auto_ticks <= auto_ticks + 1;
      end
   end

   always @(negedge clk) if (!rst && rd_req) rlog.push_back('{addr: rd_addr, pc: pcnt});

   function automatic logic [5:0] exp_en(input logic [23:0] d);
      logic [5:0] e;
`ifdef SM_DEBUG_SCAN_BLANK_EN
      for (int i = 0; i < 6; i++) e[i] = (i == 0) || ((d >> (4 * i)) != 0);
`else
      e = 6'h3f;
`endif
      return e;
   endfunction

   function automatic int cnt_win(input int lo, input int hi);
      int n = 0;
      foreach (rlog[i]) if (rlog[i].pc >= lo && rlog[i].pc <= hi) n++;
      return n;
   endfunction

   function automatic int addr_at(input int pc);
      int a = -1;
      foreach (rlog[i]) if (rlog[i].pc == pc) a = int'(rlog[i].addr);
      return a;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nclk();
      @(negedge clk);
      #1;
   endtask

   task automatic align(input int ph);
      for (int k = 0; k < 40 && (pcnt % PERIOD != ph); k++) nclk();
   endtask

   task automatic wait_pc(input int pc);
      for (int k = 0; k < 200 && pcnt < pc; k++) nclk();
   endtask

   // Waits (bounded) for the next read strobe, then for its data to reach the display.
   task automatic await_read(output int a);
      int n0 = rlog.size();
      for (int k = 0; k < 40 && rlog.size() == n0; k++) nclk();
      chk("read_seen", 32'(rlog.size() > n0), 32'd1);
      a = (rlog.size() > n0) ? int'(rlog[n0].addr) : -1;
      nclk();
      nclk();
   endtask

   initial begin
      int a, m0, e;
      logic [31:0] v;
      steps_m  = 0;
      merged_m = 0;
      rd_data  = '0;
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[3] = 32'h00AB_CDEF;
      rst = 1'b1; key_step = 1'b1; auto_en = 1'b0; base_addr = 5'd3;
      nclk(); nclk();
      chk("rst_rd_req",  32'(rd_req),    32'd0);
      chk("rst_rd_addr", 32'(rd_addr),   32'd0);
      chk("rst_disp",    32'(disp_data), 32'd0);
      chk("rst_cur",     32'(cur_addr),  32'd0);
      chk("rst_busy",    32'(busy),      32'd0);
      chk("rst_en",      32'(digit_en),  32'(exp_en(24'd0)));

      // First read after release targets base_addr.
      rst = 1'b0;
      nclk();
      chk("init_req",  32'(rd_req),  32'd1);
      chk("init_addr", 32'(rd_addr), 32'd3);
      chk("init_busy", 32'(busy),    32'd1);
      nclk();
      chk("latch_req",  32'(rd_req), 32'd0);
      chk("latch_busy", 32'(busy),   32'd1);
      nclk();
      chk("first_disp", 32'(disp_data),   32'h00AB_CDEF);
      chk("first_cur",  32'(cur_addr),    32'd3);
      chk("first_busy", 32'(busy),        32'd0);
      chk("first_cnt",  32'(rlog.size()), 32'd1);

      // Manual-mode refresh re-reads the same address on each tick.
      mem[3] = 32'h1;
      await_read(a);
      chk("ref1_addr", 32'(a), 32'd3);
      chk("ref1_disp", 32'(disp_data), 32'h1);
      chk("ref1_en",   32'(digit_en),  32'(exp_en(24'h1)));
      mem[3] = 32'h2;
      await_read(a);
      chk("ref2_addr",  32'(a),         32'd3);
      chk("ref2_disp",  32'(disp_data), 32'h2);
      chk("ref2_rdadr", 32'(rd_addr),   32'd3);
      mem[3] = 32'h0000_0A05;
      await_read(a);
      chk("blank_disp", 32'(disp_data), 32'h000A05);
`ifdef SM_DEBUG_SCAN_BLANK_EN
      chk("blank_en", 32'(digit_en), 32'h07);
`else
      chk("blank_en", 32'(digit_en), 32'h3f);
`endif

      // A base change alone triggers nothing; it applies at the next read.
      align(4);
      e = rlog.size();
      base_addr = 5'd10;
      repeat (6) nclk();
      chk("base_noread", 32'(rlog.size()), 32'(e));
      await_read(a);
      chk("base_addr", 32'(a), 32'd10);
      chk("base_disp", 32'(disp_data), 32'(mem[10][23:0]));
      base_addr = 5'd3;

      // Pressed 10 cycles, then bounce: exactly one step, read at address 4 before the next tick.
      align(1);
      m0 = pcnt;
      key_step = 1'b0;
      repeat (10) nclk();
      key_step = 1'b1; nclk();
      key_step = 1'b0; nclk();
      key_step = 1'b1;
      steps_m = 1;
      wait_pc(m0 + 17);
      chk("step_cnt",   32'(cnt_win(m0, m0 + 14)), 32'd1);
      chk("step_addr",  32'(addr_at(m0 + 6)),      32'd4);
      chk("step_tick",  32'(addr_at(m0 + 15)),     32'd4);
      chk("step_disp",  32'(disp_data),            32'(mem[4][23:0]));

      // Auto mode: a step landing during the tick's read sets pending -> one extra read.
      align(11);
      m0 = pcnt;
      auto_en = 1'b1;
      key_step = 1'b0;
      repeat (8) nclk();
      key_step = 1'b1;
      steps_m = 2;
      wait_pc(m0 + 22);
      chk("pend_cnt",  32'(cnt_win(m0, m0 + 21)), 32'd3);
      chk("pend_a0",   32'(addr_at(m0 + 5)),      32'd5);
      chk("pend_a1",   32'(addr_at(m0 + 8)),      32'd6);
      chk("pend_a2",   32'(addr_at(m0 + 21)),     32'd7);

      // Step and tick on the same edge count as one advance.
      align(10);
      m0 = pcnt;
      key_step = 1'b0;
      repeat (8) nclk();
      key_step = 1'b1;
      steps_m  = 3;
      merged_m = 1;
      wait_pc(m0 + 23);
      chk("coin_cnt", 32'(cnt_win(m0, m0 + 22)), 32'd2);
      chk("coin_a0",  32'(addr_at(m0 + 6)),      32'd8);
      chk("coin_a1",  32'(addr_at(m0 + 22)),     32'd9);

      // Randomized auto-scan with moving base and random data.
      for (int it = 0; it < 8; it++) begin
         align(4);
         base_addr = 5'($urandom_range(0, 31));
         e = (int'(base_addr) + steps_m - merged_m + auto_ticks + 1) % 32;
         v = $urandom >> (4 * $urandom_range(0, 7));
         mem[e] = v;
         await_read(a);
         chk("rnd_addr", 32'(a),         32'(e));
         chk("rnd_disp", 32'(disp_data), 32'(v[23:0]));
         chk("rnd_cur",  32'(cur_addr),  32'(e));
         chk("rnd_en",   32'(digit_en),  32'(exp_en(v[23:0])));
      end

      // Reset in the middle of a read aborts it; scanning restarts at base_addr.
      e = rlog.size();
      for (int k = 0; k < 40 && rlog.size() == e; k++) nclk();
      chk("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      base_addr = 5'd30;
      nclk();
      rlog.delete();
      chk("abort_req",  32'(rd_req),    32'd0);
      chk("abort_busy", 32'(busy),      32'd0);
      chk("abort_disp", 32'(disp_data), 32'd0);
      chk("abort_cur",  32'(cur_addr),  32'd0);
      mem[1] = $urandom;
      rst = 1'b0;
      wait_pc(50);
      chk("wrap_cnt", 32'(rlog.size()),   32'd4);
      chk("wrap_a0",  32'(addr_at(1)),    32'd30);
      chk("wrap_a1",  32'(addr_at(16)),   32'd31);
      chk("wrap_a2",  32'(addr_at(32)),   32'd0);
      chk("wrap_a3",  32'(addr_at(48)),   32'd1);
      chk("wrap_disp", 32'(disp_data),    32'(mem[1][23:0]));
      chk("wrap_cur",  32'(cur_addr),     32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
